// File: rtl/muldiv_seq.sv
// Multi-cycle radix-2 multiply/divide sequencer that owns the HI/LO pair.
// Shift-add multiply, restoring divide, sign fix-up in a final state.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] x,
  input  logic [XLEN-1:0] y,
  input  logic            hilo_rd,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic            stall,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  state_t state, state_n;

  logic [XLEN-1:0] acc, quo, mcand, xr;
  logic [CW-1:0]   cnt;
  logic            is_div, neg_q, neg_r, divz;

  logic            accept, sx, sy;
  logic [XLEN-1:0] xm, ym;
  logic [XLEN:0]   msum, dt;
  logic            dge;
  logic [XLEN-1:0] dsub, q_s, r_s;
  logic [2*XLEN-1:0] prod, prod_s;

  assign accept = (state == IDLE) & start & ~flush & ~op[2];
  assign sx     = ~op[0] & x[XLEN-1];
  assign sy     = ~op[0] & y[XLEN-1];
  assign xm     = sx ? -x : x;
  assign ym     = sy ? -y : y;

  assign busy  = (state != IDLE);
  assign stall = busy & (start | hilo_rd);

  // acc is the running high product / partial remainder, quo the low half / quotient
  assign msum = {1'b0, acc} + {1'b0, (quo[0] ? mcand : '0)};
  assign dt   = {acc, quo[XLEN-1]};
  assign dge  = dt >= {1'b0, mcand};
  assign dsub = dt[XLEN-1:0] - mcand;

  assign prod   = {acc, quo};
  assign prod_s = neg_q ? -prod : prod;
  assign q_s    = neg_q ? -quo : quo;
  assign r_s    = neg_r ? -acc : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept) state_n = CALC;
      CALC: begin
        if (flush)                      state_n = IDLE;
        else if (cnt == CW'(XLEN - 1))  state_n = SIGN;
      end
      SIGN:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      quo    <= '0;
      mcand  <= '0;
      xr     <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      divz   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= (state == SIGN) & ~flush;
      unique case (state)
        IDLE: begin
          if (accept) begin
            acc    <= '0;
            cnt    <= '0;
            xr     <= x;
            is_div <= op[1];
            neg_q  <= sx ^ sy;
            neg_r  <= sx;
            divz   <= op[1] & (y == '0);
            mcand  <= op[1] ? ym : xm;
            quo    <= op[1] ? xm : ym;
          end else if (start & ~flush & (op == 3'd4)) begin
            hi <= x;
          end else if (start & ~flush & (op == 3'd5)) begin
            lo <= x;
          end
        end
        CALC: begin
          if (!flush) begin
            cnt <= cnt + 1'b1;
            if (is_div) begin
              acc <= dge ? dsub : dt[XLEN-1:0];
              quo <= {quo[XLEN-2:0], dge};
            end else begin
              acc <= msum[XLEN:1];
              quo <= {msum[0], quo[XLEN-1:1]};
            end
          end
        end
        SIGN: begin
          if (!flush) begin
            if (!is_div) begin
              hi <= prod_s[2*XLEN-1:XLEN];
              lo <= prod_s[XLEN-1:0];
            end else if (divz) begin
              hi <= xr;
              lo <= '1;
            end else begin
              hi <= r_s;
              lo <= q_s;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq.
// Each scenario task drives its vectors and checks results inline.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] x = '0;
  logic [31:0] y = '0;
  logic        hilo_rd = 1'b0;
  logic        flush = 1'b0;
  logic        busy, done, stall;
  logic [31:0] hi, lo;

  int n_chk = 0;
  int n_err = 0;

  muldiv_seq #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .x(x), .y(y), .hilo_rd(hilo_rd), .flush(flush),
    .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Issue one op; lat = edges from accept to done rising (0 on timeout),
  // bc = number of post-edge samples with busy high before done.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, output int lat, output int bc);
    @(negedge clk);
    start = 1'b1; op = o; x = a; y = b;
    @(posedge clk); #1;
    start = 1'b0; x = '1; y = '1;
    lat = 0;
    bc = busy ? 1 : 0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
      if (busy) bc++;
    end
  endtask

  task automatic test_reset();
    n_chk++;
    if ({busy, done, stall} !== 3'b000 || hi !== 0 || lo !== 0) begin
      n_err++;
      $display("FAIL reset: busy=%b done=%b stall=%b hi=%h lo=%h want 0",
               busy, done, stall, hi, lo);
    end
  endtask

  task automatic test_mult();
    int lat, bc;
    do_op(3'd0, 32'hFFFFFFFD, 32'd7, lat, bc);
    n_chk++;
    if (lat !== 33) begin
      n_err++; $display("FAIL mult_latency: got %0d want 33", lat);
    end
    n_chk++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin
      n_err++; $display("FAIL mult_result: hi=%h lo=%h want ffffffff ffffffeb", hi, lo);
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL mult_busy_at_done: busy=%b want 0", busy);
    end
    @(posedge clk); #1;
    n_chk++;
    if (done !== 1'b0) begin
      n_err++; $display("FAIL done_pulse: done=%b want 0", done);
    end
  endtask

  task automatic test_multu();
    int lat, bc;
    do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc);
    n_chk++;
    if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
      n_err++; $display("FAIL multu_result: hi=%h lo=%h want fffffffe 00000001", hi, lo);
    end
    n_chk++;
    if (bc !== 33) begin
      n_err++; $display("FAIL multu_busy_cycles: got %0d want 33", bc);
    end
  endtask

  task automatic test_div();
    logic [2:0]  vo [5];
    logic [31:0] va [5], vb [5], eh [5], el [5];
    int lat, bc;
    vo[0] = 3'd2; va[0] = 32'hFFFFFFF9; vb[0] = 32'd2;
    eh[0] = 32'hFFFFFFFF; el[0] = 32'hFFFFFFFD;
    vo[1] = 3'd3; va[1] = 32'd7; vb[1] = 32'd0;
    eh[1] = 32'd7; el[1] = 32'hFFFFFFFF;
    vo[2] = 3'd2; va[2] = 32'h80000000; vb[2] = 32'hFFFFFFFF;
    eh[2] = 32'd0; el[2] = 32'h80000000;
    vo[3] = 3'd2; va[3] = 32'd7; vb[3] = 32'hFFFFFFFE;
    eh[3] = 32'd1; el[3] = 32'hFFFFFFFD;
    vo[4] = 3'd2; va[4] = 32'hFFFFFFFB; vb[4] = 32'd0;
    eh[4] = 32'hFFFFFFFB; el[4] = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      do_op(vo[i], va[i], vb[i], lat, bc);
      n_chk++;
      if (lat !== 33 || hi !== eh[i] || lo !== el[i]) begin
        n_err++;
        $display("FAIL div_%0d: lat=%0d hi=%h lo=%h want 33 %h %h",
                 i, lat, hi, lo, eh[i], el[i]);
      end
    end
  endtask

  task automatic test_stall();
    int sc = 0;
    bit seen = 0;
    @(negedge clk);
    start = 1'b1; op = 3'd1; x = 32'd3; y = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; op = 3'd3; x = 32'd40; y = 32'd3; hilo_rd = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
      if (stall) sc++;
    end
    n_chk++;
    if (!seen || sc !== 29) begin
      n_err++; $display("FAIL stall_cycles: seen=%0d got %0d want 29", seen, sc);
    end
    n_chk++;
    if (stall !== 1'b0 || hi !== 32'd0 || lo !== 32'd15) begin
      n_err++; $display("FAIL stall_result: stall=%b hi=%h lo=%h want 0 0 f", stall, hi, lo);
    end
    start = 1'b0; hilo_rd = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL stall_no_accept: busy=%b want 0", busy);
    end
  endtask

  task automatic test_flush();
    int dc = 0;
    @(negedge clk);
    start = 1'b1; op = 3'd3; x = 32'd100; y = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_chk++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL flush_busy: busy=%b want 0", busy);
    end
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dc++;
    end
    n_chk++;
    if (dc !== 0 || hi !== 32'd0 || lo !== 32'd15) begin
      n_err++; $display("FAIL flush_state: dones=%0d hi=%h lo=%h want 0 0 f", dc, hi, lo);
    end
    @(negedge clk);
    start = 1'b1; op = 3'd4; x = 32'h1234;
    @(posedge clk); #1;
    start = 1'b0;
    n_chk++;
    if (hi !== 32'h1234 || lo !== 32'd15 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL mthi: hi=%h lo=%h busy=%b done=%b want 1234 f 0 0",
                        hi, lo, busy, done);
    end
  endtask

  task automatic test_async_reset();
    int lat, bc;
    @(negedge clk);
    start = 1'b1; op = 3'd0; x = 32'd9; y = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #2 rst_n = 1'b0;
    hilo_rd = 1'b1;
    #1;
    n_chk++;
    if ({busy, done, stall} !== 3'b000 || hi !== 0 || lo !== 0) begin
      n_err++; $display("FAIL async_reset: busy=%b done=%b stall=%b hi=%h lo=%h want 0",
                        busy, done, stall, hi, lo);
    end
    hilo_rd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_op(3'd1, 32'd2, 32'd3, lat, bc);
    n_chk++;
    if (lat !== 33 || hi !== 32'd0 || lo !== 32'd6) begin
      n_err++; $display("FAIL post_reset_multu: lat=%0d hi=%h lo=%h want 33 0 6", lat, hi, lo);
    end
  endtask

  task automatic test_ignored_op();
    @(negedge clk);
    start = 1'b1; op = 3'd6; x = 32'hDEAD;
    @(posedge clk); #1;
    start = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd6) begin
      n_err++; $display("FAIL ignored_op: busy=%b hi=%h lo=%h want 0 0 6", busy, hi, lo);
    end
  endtask

  initial begin
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_mult();
    test_multu();
    test_div();
    test_stall();
    test_flush();
    test_async_reset();
    test_ignored_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
